// File: rtl/serial_rx_pkg.sv
// -----------------------------------------------------------------------------
// serial_rx_pkg
// Shared types and constants for the multi-lane serial receiver.
//   rx_state_t  : frame decoder state
//   rx_entry_t  : one output FIFO entry (lane, data byte and, when
//                 SERIAL_RX_ERR_FORWARD_EN is defined, the frame error flag)
// -----------------------------------------------------------------------------
package serial_rx_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;
    // Widest lane index the design supports (NUM_LANES up to 8).
    localparam int LANE_W_MAX = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    typedef struct packed {
`ifdef SERIAL_RX_ERR_FORWARD_EN
        logic                  err;
`endif
        logic [LANE_W_MAX-1:0] lane;
        logic [DATA_BITS-1:0]  data;
    } rx_entry_t;

endpackage

// File: rtl/serial_rx_arbiter_if.sv
// -----------------------------------------------------------------------------
// serial_rx_arbiter_if
// Bundles the serial lanes, the output byte stream and the status pulses.
//   I_SERIAL_DATA : one serial line per lane (idles low)
//   O_VALID/I_READY/O_DATA/O_LANE : output byte stream
//   O_ERROR/O_OVERFLOW/O_COLLISION : one-cycle status pulses
//   O_FRAME_ERR   : head entry error flag (only with SERIAL_RX_ERR_FORWARD_EN)
//   dbg_state     : decoder state, for observation only
//
// Handshake: a byte transfers on every rising clk edge where O_VALID and
// I_READY are both high. O_VALID never depends on I_READY, and O_DATA/O_LANE
// (and O_FRAME_ERR) hold stable while O_VALID is high and I_READY is low.
//
// slave  : the receiver side (drives the O_* signals)
// master : the environment side (drives the serial lines and I_READY)
// -----------------------------------------------------------------------------
interface serial_rx_arbiter_if #(
    parameter int NUM_LANES = 4
);
    localparam int LANE_W = $clog2(NUM_LANES);

    logic [NUM_LANES-1:0]    I_SERIAL_DATA;
    logic                    O_VALID;
    logic                    I_READY;
    logic [7:0]              O_DATA;
    logic [LANE_W-1:0]       O_LANE;
    logic                    O_ERROR;
    logic                    O_OVERFLOW;
    logic                    O_COLLISION;
`ifdef SERIAL_RX_ERR_FORWARD_EN
    logic                    O_FRAME_ERR;
`endif
    serial_rx_pkg::rx_state_t dbg_state;

    modport slave (
        input  I_SERIAL_DATA, I_READY,
        output O_VALID, O_DATA, O_LANE, O_ERROR, O_OVERFLOW, O_COLLISION,
`ifdef SERIAL_RX_ERR_FORWARD_EN
        output O_FRAME_ERR,
`endif
        output dbg_state
    );

    modport master (
        output I_SERIAL_DATA, I_READY,
        input  O_VALID, O_DATA, O_LANE, O_ERROR, O_OVERFLOW, O_COLLISION,
`ifdef SERIAL_RX_ERR_FORWARD_EN
        input  O_FRAME_ERR,
`endif
        input  dbg_state
    );

endinterface

// File: rtl/serial_rx_fifo.sv
// -----------------------------------------------------------------------------
// serial_rx_fifo
// Synchronous FIFO of rx_entry_t, no fall-through.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write request and entry; accepted when not full, or when full
//              together with an accepted pop
//   pop      : read request; ignored while empty
//   dout     : head entry (all zero after reset)
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module serial_rx_fifo
    import serial_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  rx_entry_t din,
    input  logic      pop,
    output rx_entry_t dout,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);

    rx_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_rx_arbiter.sv
// -----------------------------------------------------------------------------
// serial_rx_arbiter
// Shares one 11-bit frame decoder among NUM_LANES serial inputs. A start bit
// (1) on any lane is granted round-robin, then 8 data bits (LSB first), an
// even parity bit and a stop bit (0) are taken from the granted lane. Good
// bytes go into an output FIFO tagged with their lane.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : serial_rx_arbiter_if slave modport (lanes, byte stream, pulses,
//              decoder state)
// Optional feature macro: SERIAL_RX_ERR_FORWARD_EN -- bad frames are pushed as
// well, flagged through O_FRAME_ERR.
// -----------------------------------------------------------------------------
module serial_rx_arbiter
    import serial_rx_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_rx_arbiter_if.slave  bus
);
    localparam int LANE_W = $clog2(NUM_LANES);

    rx_state_t              state;
    logic [LANE_W-1:0]      rr_ptr;
    logic [LANE_W-1:0]      lane_q;
    logic [2:0]             bit_cnt;
    logic [DATA_BITS-1:0]   data_q;
    logic                   par_acc;
    logic                   par_err;
    logic                   err_q;
    logic                   ovf_q;
    logic                   col_q;

    logic [NUM_LANES-1:0]   req;
    logic                   grant_any;
    logic [LANE_W-1:0]      grant_idx;
    logic [LANE_W-1:0]      rr_next;
    logic                   multi_req;
    logic                   cur_bit;
    logic                   frame_good;
    logic                   push_req;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    rx_entry_t              fifo_din;
    rx_entry_t              fifo_head;
    logic                   unused_lane_bits;

    assign req       = bus.I_SERIAL_DATA;
    assign cur_bit   = bus.I_SERIAL_DATA[lane_q];
    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign multi_req = |(req & (req - NUM_LANES'(1)));

    // First requesting lane at or after rr_ptr. The loop walks offsets from
    // the far end so the smallest offset is the last (winning) assignment.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_LANES) begin
                idx = idx - NUM_LANES;
            end
            if (req[LANE_W'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = LANE_W'(idx);
            end
        end
    end

    assign rr_next = (grant_idx == LANE_W'(NUM_LANES - 1)) ? '0
                                                          : grant_idx + LANE_W'(1);

    assign frame_good = !par_err && !cur_bit;
`ifdef SERIAL_RX_ERR_FORWARD_EN
    assign push_req   = (state == ST_STOP);
`else
    assign push_req   = (state == ST_STOP) && frame_good;
`endif
    assign fifo_pop   = !fifo_empty && bus.I_READY;

    always_comb begin
        fifo_din      = '0;
        fifo_din.lane = LANE_W_MAX'(lane_q);
        fifo_din.data = data_q;
`ifdef SERIAL_RX_ERR_FORWARD_EN
        fifo_din.err  = !frame_good;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            lane_q  <= '0;
            bit_cnt <= '0;
            data_q  <= '0;
            par_acc <= 1'b0;
            par_err <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            col_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            ovf_q <= 1'b0;
            col_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        lane_q  <= grant_idx;
                        rr_ptr  <= rr_next;
                        bit_cnt <= '0;
                        par_acc <= 1'b0;
                        col_q   <= multi_req;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    data_q  <= {cur_bit, data_q[DATA_BITS-1:1]};
                    par_acc <= par_acc ^ cur_bit;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_err <= (cur_bit != par_acc);
                    state   <= ST_STOP;
                end
                ST_STOP: begin
                    err_q <= !frame_good;
                    // Lost only when full and the head is not leaving now.
                    ovf_q <= push_req && fifo_full && !fifo_pop;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    serial_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The stored lane field is sized for the largest lane count.
    assign unused_lane_bits = ^fifo_head.lane;

    assign bus.O_VALID     = !fifo_empty;
    assign bus.O_DATA      = fifo_head.data;
    assign bus.O_LANE      = fifo_head.lane[LANE_W-1:0];
    assign bus.O_ERROR     = err_q;
    assign bus.O_OVERFLOW  = ovf_q;
    assign bus.O_COLLISION = col_q;
`ifdef SERIAL_RX_ERR_FORWARD_EN
    assign bus.O_FRAME_ERR = fifo_head.err;
`endif
    assign bus.dbg_state   = state;

endmodule

// File: tb/tb_serial_rx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serial_rx_arbiter
// Directed bench for serial_rx_arbiter (NUM_LANES = 4, FIFO_DEPTH = 4).
// Inputs change 1 ns after the rising edge; outputs are read there too.
// Honours SERIAL_RX_ERR_FORWARD_EN when defined.
// -----------------------------------------------------------------------------
module tb_serial_rx_arbiter;
    import serial_rx_pkg::*;

    localparam int NL = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_rx_arbiter_if #(.NUM_LANES(NL)) bus ();

    serial_rx_arbiter #(
        .NUM_LANES  (NL),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    logic [10:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Snapshots taken by send_frame.
    logic       s_col1, s_col2, s_valid, s_err, s_ovf;
    logic [7:0] s_data;
    logic [1:0] s_lane;
`ifdef SERIAL_RX_ERR_FORWARD_EN
    logic       s_ferr;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input logic par,
                                       input logic stop, input int k);
        if (k == 0)      return 1'b1;
        else if (k <= 8) return d[3'(k - 1)];
        else if (k == 9) return par;
        else             return stop;
    endfunction

    // ---------------- driver tasks ----------------
    // Start bit is in the cycle where the task begins (cycle t); returns 1 ns
    // into cycle t+11 with the output state captured.
    task automatic send_frame(input logic [NL-1:0] mask, input logic [7:0] d,
                              input logic par, input logic stop,
                              input logic ready_at_stop);
        for (int k = 0; k < 11; k++) begin
            bus.I_SERIAL_DATA = mask & {NL{frame_bit(d, par, stop, k)}};
            if (k == 10 && ready_at_stop) bus.I_READY = 1'b1;
            @(posedge clk);
            #1;
            if (k == 0) s_col1 = bus.O_COLLISION;
            if (k == 1) s_col2 = bus.O_COLLISION;
        end
        bus.I_SERIAL_DATA = '0;
        bus.I_READY       = 1'b0;
        s_valid = bus.O_VALID;
        s_err   = bus.O_ERROR;
        s_ovf   = bus.O_OVERFLOW;
        s_data  = bus.O_DATA;
        s_lane  = bus.O_LANE;
`ifdef SERIAL_RX_ERR_FORWARD_EN
        s_ferr  = bus.O_FRAME_ERR;
`endif
    endtask

    task automatic idle_cycle();
        bus.I_SERIAL_DATA = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        logic [10:0] e;
        e = exp_q.pop_front();
        check({tag, "_valid"}, 32'(bus.O_VALID), 1);
        check({tag, "_lane"},  32'(bus.O_LANE), 32'(e[9:8]));
        check({tag, "_data"},  32'(bus.O_DATA), 32'(e[7:0]));
`ifdef SERIAL_RX_ERR_FORWARD_EN
        check({tag, "_ferr"},  32'(bus.O_FRAME_ERR), 0);
`endif
        bus.I_READY = 1'b1;
        @(posedge clk);
        #1;
        bus.I_READY = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0) begin
            pop_check($sformatf("%s_pop%0d", tag, n));
            n++;
        end
        check({tag, "_empty"}, 32'(bus.O_VALID), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst               = 1'b1;
        bus.I_SERIAL_DATA = '0;
        bus.I_READY       = 1'b0;
        #1;
        check("rst_valid", 32'(bus.O_VALID), 0);
        check("rst_data",  32'(bus.O_DATA), 0);
        check("rst_lane",  32'(bus.O_LANE), 0);
        check("rst_err",   32'(bus.O_ERROR), 0);
        check("rst_ovf",   32'(bus.O_OVERFLOW), 0);
        check("rst_col",   32'(bus.O_COLLISION), 0);
        check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycle();

        // Lane 2, 0xA5 (four ones -> parity 0), good.
        send_frame(4'b0100, 8'hA5, 1'b0, 1'b0, 1'b0);
        check("t1_col",   32'(s_col1), 0);
        check("t1_valid", 32'(s_valid), 1);
        check("t1_data",  32'(s_data), 'hA5);
        check("t1_lane",  32'(s_lane), 2);
        check("t1_err",   32'(s_err), 0);
        check("t1_ovf",   32'(s_ovf), 0);
        idle_cycle();
        check("t1_hold_data", 32'(bus.O_DATA), 'hA5);
        exp_q.push_back({3'd2, 8'hA5});
        drain("t1");

        // Lane 0, 0x01 with parity 0 (should be 1): bad frame.
        send_frame(4'b0001, 8'h01, 1'b0, 1'b0, 1'b0);
        check("t2_err", 32'(s_err), 1);
        check("t2_ovf", 32'(s_ovf), 0);
`ifdef SERIAL_RX_ERR_FORWARD_EN
        check("t2_valid", 32'(s_valid), 1);
        check("t2_data",  32'(s_data), 'h01);
        check("t2_lane",  32'(s_lane), 0);
        check("t2_ferr",  32'(s_ferr), 1);
        bus.I_READY = 1'b1;
        @(posedge clk);
        #1;
        bus.I_READY = 1'b0;
        check("t2_err_gone", 32'(bus.O_ERROR), 0);
`else
        check("t2_valid", 32'(s_valid), 0);
        idle_cycle();
        check("t2_err_gone", 32'(bus.O_ERROR), 0);
`endif
        check("t2_empty", 32'(bus.O_VALID), 0);

        // Bad stop bit on lane 1: 0x03 parity 0 correct, stop 1.
        send_frame(4'b0010, 8'h03, 1'b0, 1'b1, 1'b0);
        check("t2b_err", 32'(s_err), 1);
`ifdef SERIAL_RX_ERR_FORWARD_EN
        check("t2b_ferr", 32'(s_ferr), 1);
        bus.I_READY = 1'b1;
        @(posedge clk);
        #1;
        bus.I_READY = 1'b0;
`else
        check("t2b_valid", 32'(s_valid), 0);
`endif

        // Lane 3 frame moves the round-robin pointer back to 0.
        send_frame(4'b1000, 8'h3C, 1'b0, 1'b0, 1'b0);
        check("t3_lane", 32'(s_lane), 3);
        exp_q.push_back({3'd3, 8'h3C});
        drain("t3");

        // Collision: lanes 0 and 1 together, twice.
        send_frame(4'b0011, 8'h0F, 1'b0, 1'b0, 1'b0);
        check("t4a_col",  32'(s_col1), 1);
        check("t4a_col2", 32'(s_col2), 0);
        check("t4a_lane", 32'(s_lane), 0);
        exp_q.push_back({3'd0, 8'h0F});
        send_frame(4'b0011, 8'hF0, 1'b0, 1'b0, 1'b0);
        check("t4b_col",  32'(s_col1), 1);
        check("t4b_head", 32'(s_data), 'h0F);
        exp_q.push_back({3'd1, 8'hF0});
        drain("t4");

        // Overflow: five back-to-back good frames with I_READY low.
        send_frame(4'b0001, 8'h11, 1'b0, 1'b0, 1'b0);
        check("t5_ovf1", 32'(s_ovf), 0);
        send_frame(4'b0010, 8'h22, 1'b0, 1'b0, 1'b0);
        check("t5_ovf2", 32'(s_ovf), 0);
        send_frame(4'b0100, 8'h33, 1'b0, 1'b0, 1'b0);
        check("t5_ovf3", 32'(s_ovf), 0);
        send_frame(4'b1000, 8'h44, 1'b0, 1'b0, 1'b0);
        check("t5_ovf4", 32'(s_ovf), 0);
        send_frame(4'b0001, 8'h55, 1'b0, 1'b0, 1'b0);
        check("t5_ovf5", 32'(s_ovf), 1);
        check("t5_head", 32'(s_data), 'h11);
        check("t5_err",  32'(s_err), 0);
        idle_cycle();
        check("t5_ovf_gone", 32'(bus.O_OVERFLOW), 0);
        exp_q.push_back({3'd0, 8'h11});
        exp_q.push_back({3'd1, 8'h22});
        exp_q.push_back({3'd2, 8'h33});
        exp_q.push_back({3'd3, 8'h44});
        drain("t5");

        // Full FIFO, head popped on the same edge as the fifth push.
        send_frame(4'b0001, 8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0010, 8'h22, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0100, 8'h33, 1'b0, 1'b0, 1'b0);
        send_frame(4'b1000, 8'h44, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0010, 8'h66, 1'b0, 1'b0, 1'b1);
        check("t6_ovf",  32'(s_ovf), 0);
        check("t6_head", 32'(s_data), 'h22);
        check("t6_lane", 32'(s_lane), 1);
        exp_q.push_back({3'd1, 8'h22});
        exp_q.push_back({3'd2, 8'h33});
        exp_q.push_back({3'd3, 8'h44});
        exp_q.push_back({3'd1, 8'h66});
        drain("t6");

        // Reset during a frame, with one byte waiting in the FIFO.
        send_frame(4'b0100, 8'hA5, 1'b0, 1'b0, 1'b0);
        check("t7_pre_valid", 32'(s_valid), 1);
        for (int k = 0; k < 5; k++) begin
            bus.I_SERIAL_DATA = 4'b0010 & {NL{frame_bit(8'h77, 1'b0, 1'b0, k)}};
            @(posedge clk);
            #1;
        end
        check("t7_mid_state", 32'(bus.dbg_state), 32'(ST_DATA));
        bus.I_SERIAL_DATA = 4'b0010 & {NL{frame_bit(8'h77, 1'b0, 1'b0, 5)}};
        #2;
        rst = 1'b1;
        #1;
        check("t7_rst_valid", 32'(bus.O_VALID), 0);
        check("t7_rst_data",  32'(bus.O_DATA), 0);
        check("t7_rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        bus.I_SERIAL_DATA = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            idle_cycle();
            check($sformatf("t7_quiet_valid%0d", k), 32'(bus.O_VALID), 0);
            check($sformatf("t7_quiet_err%0d", k), 32'(bus.O_ERROR), 0);
        end
        // rr_ptr is back at 0, so lane 0 wins over lane 2.
        send_frame(4'b0101, 8'h81, 1'b0, 1'b0, 1'b0);
        check("t7_col",  32'(s_col1), 1);
        check("t7_lane", 32'(s_lane), 0);
        check("t7_data", 32'(s_data), 'h81);
        check("t7_err",  32'(s_err), 0);
        exp_q.push_back({3'd0, 8'h81});
        drain("t7");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
